// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALTED sequencer and the IF/ID pipeline latch.
// Define IF_STAGE_PERF_CNT_EN to add saturating Fetch_count / Stall_count performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Halt,
  output logic [31:0] IF_ID_PC_plus4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic        Halted
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_count,
  output logic [31:0] Stall_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_pc_nxt;
  logic [31:0] ifid_instr_nxt;
  logic        ifid_valid_nxt;

  // Modulo-2^32 add: 32'hFFFF_FFFC wraps to zero by construction.
  assign pc_plus4 = PC + 32'd4;
  assign Halted   = (state == HALTED);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = PC;
    ifid_pc_nxt    = IF_ID_PC_plus4;
    ifid_instr_nxt = IF_ID_Instruction;
    ifid_valid_nxt = IF_ID_Valid;
    case (state)
      BOOT: begin
        state_nxt      = RUN;
        pc_nxt         = RESET_PC;
        ifid_pc_nxt    = 32'h0;
        ifid_instr_nxt = 32'h0;
        ifid_valid_nxt = 1'b0;
      end
      RUN: begin
        if (Halt) begin
          state_nxt      = HALTED;
          ifid_pc_nxt    = 32'h0;
          ifid_instr_nxt = 32'h0;
          ifid_valid_nxt = 1'b0;
        end else if (Branch_taken) begin
          // Masking keeps the target word-aligned while still using every input bit.
          pc_nxt         = Branch_target & 32'hFFFF_FFFC;
          ifid_pc_nxt    = 32'h0;
          ifid_instr_nxt = 32'h0;
          ifid_valid_nxt = 1'b0;
        end else if (Stall) begin
          if (Flush) begin
            ifid_pc_nxt    = 32'h0;
            ifid_instr_nxt = 32'h0;
            ifid_valid_nxt = 1'b0;
          end
        end else if (Flush) begin
          pc_nxt         = pc_plus4;
          ifid_pc_nxt    = 32'h0;
          ifid_instr_nxt = 32'h0;
          ifid_valid_nxt = 1'b0;
        end else begin
          pc_nxt         = pc_plus4;
          ifid_pc_nxt    = pc_plus4;
          ifid_instr_nxt = Instruction;
          ifid_valid_nxt = 1'b1;
        end
      end
      HALTED: begin
        ifid_pc_nxt    = 32'h0;
        ifid_instr_nxt = 32'h0;
        ifid_valid_nxt = 1'b0;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= BOOT;
      PC                <= RESET_PC;
      IF_ID_PC_plus4    <= 32'h0;
      IF_ID_Instruction <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else begin
      state             <= state_nxt;
      PC                <= pc_nxt;
      IF_ID_PC_plus4    <= ifid_pc_nxt;
      IF_ID_Instruction <= ifid_instr_nxt;
      IF_ID_Valid       <= ifid_valid_nxt;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic fetch_event;
  logic stall_event;

  assign fetch_event = (state == RUN) && !Halt && !Branch_taken && !Stall && !Flush;
  assign stall_event = (state == RUN) && Stall && !Branch_taken && !Halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fetch_count <= 32'h0;
      Stall_count <= 32'h0;
    end else begin
      if (fetch_event && Fetch_count != 32'hFFFF_FFFF) Fetch_count <= Fetch_count + 32'd1;
      if (stall_event && Stall_count != 32'hFFFF_FFFF) Stall_count <= Stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot latency, stall, flush, branch, PC wrap, async reset and halt.
// Counter checks are compiled in when IF_STAGE_PERF_CNT_EN is defined.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        stall, flush, branch_taken, halt;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc_plus4, if_id_instruction;
  logic        if_id_valid, halted;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word0 fixed, other addresses get a distinct address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0001_1000;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign instruction = mem_word(pc);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PC                (pc),
    .Instruction       (instruction),
    .Stall             (stall),
    .Flush             (flush),
    .Branch_taken      (branch_taken),
    .Branch_target     (branch_target),
    .Halt              (halt),
    .IF_ID_PC_plus4    (if_id_pc_plus4),
    .IF_ID_Instruction (if_id_instruction),
    .IF_ID_Valid       (if_id_valid),
    .Halted            (halted)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .Fetch_count       (fetch_count),
    .Stall_count       (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] p4, input logic [31:0] ins,
                            input logic v);
    check({tag, ".pc4"}, if_id_pc_plus4, p4);
    check({tag, ".ins"}, if_id_instruction, ins);
    check({tag, ".vld"}, {31'h0, if_id_valid}, {31'h0, v});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    branch_target = 32'h0;
    tick(); tick();
    check("rst.pc", pc, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.halted", {31'h0, halted}, 32'h0);

    // Boot latency: bubble on the first edge, first valid entry on the second.
    rst_n = 1'b1;
    tick();
    check("boot1.pc", pc, 32'h0);
    check_ifid("boot1", 32'h0, 32'h0, 1'b0);
    tick();
    check("boot2.pc", pc, 32'h4);
    check_ifid("boot2", 32'h4, 32'h0001_1000, 1'b1);
    tick();
    check("run3.pc", pc, 32'h8);
    check_ifid("run3", 32'h8, mem_word(32'h4), 1'b1);

    // Three stall cycles at PC=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", pc, 32'h8);
      check_ifid("stall", 32'h8, mem_word(32'h4), 1'b1);
    end
    stall = 1'b0;
`ifdef IF_STAGE_PERF_CNT_EN
    check("cnt.stall3", stall_count, 32'd3);
    check("cnt.fetch2", fetch_count, 32'd2);
`endif
    tick();
    check("resume.pc", pc, 32'hC);
    check_ifid("resume", 32'hC, mem_word(32'h8), 1'b1);

    // Flush alone advances PC but loads a bubble.
    flush = 1'b1;
    tick();
    check("flush.pc", pc, 32'h10);
    check_ifid("flush", 32'h0, 32'h0, 1'b0);

    // Stall plus flush: PC holds, bubble loaded.
    stall = 1'b1;
    tick();
    check("stflush.pc", pc, 32'h10);
    check_ifid("stflush", 32'h0, 32'h0, 1'b0);
    flush = 1'b0;

    // Branch overrides stall; target is word-aligned.
    branch_taken = 1'b1; branch_target = 32'h0000_0043;
    tick();
    check("br.pc", pc, 32'h40);
    check_ifid("br", 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0; stall = 1'b0;
`ifdef IF_STAGE_PERF_CNT_EN
    check("cnt.stall4", stall_count, 32'd4);
`endif
    tick();
    check("br_next.pc", pc, 32'h44);
    check_ifid("br_next", 32'h44, mem_word(32'h40), 1'b1);

    // PC wrap at the top of the address space.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    check("wrap0.pc", pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick();
    check("wrap.pc", pc, 32'h0);
    check_ifid("wrap", 32'h0, mem_word(32'hFFFF_FFFC), 1'b1);
    tick();
    check("wrap1.pc", pc, 32'h4);

    // Asynchronous reset between edges while stalled.
    stall = 1'b1;
    tick();
    check("prerst.pc", pc, 32'h4);
    #3 rst_n = 1'b0;
    #1;
    check("arst.pc", pc, 32'h0);
    check("arst.vld", {31'h0, if_id_valid}, 32'h0);
    check("arst.halted", {31'h0, halted}, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
    check("arst.fetch", fetch_count, 32'h0);
    check("arst.stall", stall_count, 32'h0);
`endif
    tick();
    rst_n = 1'b1; stall = 1'b0;
    tick();
    check("reboot1.pc", pc, 32'h0);
    tick();
    check("reboot2.pc", pc, 32'h4);
    check_ifid("reboot2", 32'h4, 32'h0001_1000, 1'b1);

    // Halt takes priority over a simultaneous branch, then ignores everything.
    branch_taken = 1'b1; branch_target = 32'h0000_0010;
    tick();
    check("pre_halt.pc", pc, 32'h10);
    halt = 1'b1; branch_target = 32'h0000_0100;
    tick();
    check("halt.halted", {31'h0, halted}, 32'h1);
    check("halt.pc", pc, 32'h10);
    check_ifid("halt", 32'h0, 32'h0, 1'b0);
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i % 2 == 0);
      flush        = (i == 1);
      stall        = (i == 3);
      tick();
      check("halted.pc", pc, 32'h10);
      check("halted.vld", {31'h0, if_id_valid}, 32'h0);
      check("halted.halted", {31'h0, halted}, 32'h1);
    end
`ifdef IF_STAGE_PERF_CNT_EN
    check("cnt.fetch_end", fetch_count, 32'd1);
    check("cnt.stall_end", stall_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
